dffe_pipe: RTL and testbench

Parametrised elastic pipeline of DFFE-type registers. It carries W-bit words through DEPTH stages with per-stage valid tracking, valid/ready backpressure and bubble collapsing, under one global clock enable. It is the generalisation of the single-stage enabled flip-flop primitive and is used for timing-closure register slices and fixed-latency data delays in datapaths.

---
 rtl/dffe_pipe_pkg.sv | 22 ++
 rtl/dffe_pipe_stage.sv | 59 +++++
 rtl/dffe_pipe.sv | 112 +++++++++++
 tb/tb_dffe_pipe.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dffe_pipe_pkg.sv
// dffe_pipe_pkg: shared constants and width helpers for the dffe_pipe
// elastic register pipeline.
package dffe_pipe_pkg;

  localparam int DEFAULT_W     = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Bits needed to hold a count from 0 to depth inclusive (ceil(log2(depth+1))),
  // never less than one bit.
  function automatic int clog2_fill(input int depth);
    int bits;
    bits = 0;
    for (int k = depth; k > 0; k = k >> 1) begin
      bits++;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  // Fill counter width for the default depth.
  localparam int FILL_W = clog2_fill(DEFAULT_DEPTH);

endpackage

// File: rtl/dffe_pipe_stage.sv
// dffe_pipe_stage: one enabled register stage of the elastic pipeline.
// It keeps a valid bit and a data word. It reports ready when it is empty
// or when the stage downstream is ready. It loads data only on valid words,
// so bubbles never toggle the data register.
// When DFFE_PIPE_SCLR_EN is defined, a synchronous clear input sclr is added.
module dffe_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         ena,
`ifdef DFFE_PIPE_SCLR_EN
  input  logic         sclr,
`endif
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_rdy,
  output logic         rdy,
  output logic         v,
  output logic [W-1:0] r
);

  logic         v_q, v_d;
  logic [W-1:0] r_q, r_d;

  assign rdy = ~v_q | dn_rdy;
  assign v   = v_q;
  assign r   = r_q;

  // Next state: move when enabled and ready. Capture data only for a real word.
  always_comb begin
    v_d = v_q;
    r_d = r_q;
    if (ena && rdy) begin
      v_d = up_valid;
      if (up_valid) begin
        r_d = up_data;
      end
    end
`ifdef DFFE_PIPE_SCLR_EN
    if (sclr) begin
      v_d = 1'b0;
      r_d = '0;
    end
`endif
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v_q <= 1'b0;
      r_q <= '0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/dffe_pipe.sv
// dffe_pipe: elastic pipeline of DEPTH enabled register stages.
// It has valid/ready handshakes, bubble collapsing and a global enable.
// A combinational ready chain runs from out_ready back to in_ready.
// Optional build macro DFFE_PIPE_SCLR_EN adds the synchronous clear input sclr.
module dffe_pipe
  import dffe_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clrn,
  input  logic                           ena,
`ifdef DFFE_PIPE_SCLR_EN
  input  logic                           sclr,
`endif
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W-1:0]                   d,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   q,
  output logic [clog2_fill(DEPTH)-1:0]   fill,
  output logic                           full,
  output logic                           empty
);

  localparam int FW = clog2_fill(DEPTH);

  logic          sclr_w;
  logic          accept, deliver;
  logic [FW-1:0] fill_q, fill_d;

`ifdef DFFE_PIPE_SCLR_EN
  assign sclr_w = sclr;
`else
  assign sclr_w = 1'b0;
`endif

  // Each stage keeps its chain signals local to its generate scope.
  // The ready chain therefore spans separate nets, not bits of one shared vector.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic         up_valid;
    logic [W-1:0] up_data;
    logic         dn_rdy;
    logic         rdy;
    logic         v;
    logic [W-1:0] r;

    if (gi == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = d;
    end else begin : g_link
      assign up_valid = g_stage[gi-1].v;
      assign up_data  = g_stage[gi-1].r;
    end

    if (gi == DEPTH - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_next
      assign dn_rdy = g_stage[gi+1].rdy;
    end

    dffe_pipe_stage #(.W(W)) u_stage (
      .clk      (clk),
      .clrn     (clrn),
      .ena      (ena),
`ifdef DFFE_PIPE_SCLR_EN
      .sclr     (sclr),
`endif
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_rdy   (dn_rdy),
      .rdy      (rdy),
      .v        (v),
      .r        (r)
    );
  end

  assign in_ready  = ena & g_stage[0].rdy & ~sclr_w;
  assign out_valid = ena & g_stage[DEPTH-1].v & ~sclr_w;
  assign q         = g_stage[DEPTH-1].r;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // Occupancy tracks port transfers. A transfer on both ports leaves it unchanged.
  always_comb begin
    fill_d = fill_q;
    if (sclr_w) begin
      fill_d = '0;
    end else if (accept && !deliver) begin
      fill_d = fill_q + FW'(1);
    end else if (deliver && !accept) begin
      fill_d = fill_q - FW'(1);
    end
  end

  // Occupancy register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill  = fill_q;
  assign full  = (fill_q == FW'(DEPTH));
  assign empty = (fill_q == '0);

endmodule

// File: tb/tb_dffe_pipe.sv
// tb_dffe_pipe: directed and randomized bench for dffe_pipe (W=8, DEPTH=4).
// The reference model tracks each word in flight by its stage position.
// Optional build macro DFFE_PIPE_SCLR_EN enables the sclr scenario.
module tb_dffe_pipe;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       clrn, ena, in_valid, out_ready;
  logic [7:0] d;
  logic       in_ready, out_valid, full, empty;
  logic [7:0] q;
  logic [2:0] fill;
`ifdef DFFE_PIPE_SCLR_EN
  logic       sclr;
`endif

  dffe_pipe #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ena       (ena),
`ifdef DFFE_PIPE_SCLR_EN
    .sclr      (sclr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .fill      (fill),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words in flight, oldest first, with their stage index.
  int         m_pos[$];
  logic [7:0] m_dat[$];
  logic [7:0] m_q;

  task automatic model_reset();
    m_pos.delete();
    m_dat.delete();
    m_q = 8'h00;
  endtask

  // Returns the highest stage index left free for a new word at stage 0.
  // Each word advances one stage unless the word ahead of it blocks it.
  // The function works through the words from oldest to newest.
  function automatic int m_free_lim(input logic ordy);
    int lim;
    int start;
    int np;
    lim   = DEPTH - 1;
    start = 0;
    if (m_pos.size() > 0 && m_pos[0] == DEPTH - 1 && ordy) start = 1;
    for (int i = start; i < m_pos.size(); i++) begin
      np  = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
      lim = np - 1;
    end
    return lim;
  endfunction

  function automatic logic m_in_ready(input logic ordy, input logic en);
    return en && (m_free_lim(ordy) >= 0);
  endfunction

  function automatic logic m_out_valid(input logic en);
    return en && m_pos.size() > 0 && m_pos[0] == DEPTH - 1;
  endfunction

  task automatic model_edge(input logic iv, input logic [7:0] dd, input logic ordy, input logic en);
    logic acc;
    int   lim;
    int   np;
    if (!en) return;
    acc = iv && m_in_ready(ordy, en);
    if (m_out_valid(en) && ordy) begin
      m_pos.delete(0);
      m_dat.delete(0);
    end
    lim = DEPTH - 1;
    for (int i = 0; i < m_pos.size(); i++) begin
      np = (m_pos[i] + 1 < lim) ? m_pos[i] + 1 : lim;
      if (np == DEPTH - 1 && m_pos[i] != DEPTH - 1) m_q = m_dat[i];
      m_pos[i] = np;
      lim = np - 1;
    end
    if (acc) begin
      m_pos.push_back(0);
      m_dat.push_back(dd);
      if (DEPTH == 1) m_q = dd;
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] dd, input logic ordy, input logic en);
    @(negedge clk);
    in_valid  = iv;
    d         = dd;
    out_ready = ordy;
    ena       = en;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(in_valid, d, out_ready, ena);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (q !== 8'h60 || full !== 1'b1) $display("FAIL reset_preload q=%h full=%b exp q=60 full=1", q, full); else n_pass++;
    tick();
    #2 clrn = 1'b0;
    #1;
    model_reset();
    n_checks++; if (q !== 8'h00) $display("FAIL reset_q got=%h exp=00", q); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (fill !== 3'd0) $display("FAIL reset_fill got=%0d exp=0", fill); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", empty, full); else n_pass++;
    @(negedge clk);
    clrn = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    $display("reset: pipe cleared and released");
  endtask

  task automatic test_latency();
    logic [7:0] vals [3];
    logic [7:0] exp_q;
    logic       exp_ov;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 8; i++) begin
      drive(i < 3, (i < 3) ? vals[i] : 8'h00, 1'b1, 1'b1);
      exp_ov = (i >= 4 && i <= 6);
      exp_q  = (i >= 4 && i <= 6) ? vals[i-4] : 8'h00;
      n_checks++; if (out_valid !== exp_ov) $display("FAIL lat_out_valid cyc=%0d got=%b exp=%b", i, out_valid, exp_ov); else n_pass++;
      if (exp_ov) begin
        n_checks++; if (q !== exp_q) $display("FAIL lat_q cyc=%0d got=%h exp=%h", i, q, exp_q); else n_pass++;
        $display("latency: cycle %0d delivered %h", i, q);
      end
      n_checks++; if (fill !== 3'(m_pos.size())) $display("FAIL lat_fill cyc=%0d got=%0d exp=%0d", i, fill, m_pos.size()); else n_pass++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_fill_in_ready i=%0d got=%b exp=1", i, in_ready); else n_pass++;
      tick();
    end
    drive(1'b1, 8'hA4, 1'b0, 1'b1);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (fill !== 3'd4 || full !== 1'b1) $display("FAIL bp_full_fill fill=%0d full=%b exp 4/1", fill, full); else n_pass++;
    n_checks++; if (q !== 8'hA0 || out_valid !== 1'b1) $display("FAIL bp_full_q q=%h ov=%b exp A0/1", q, out_valid); else n_pass++;
    tick();
    drive(1'b1, 8'hA4, 1'b1, 1'b1);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_pass_in_ready got=%b exp=1", in_ready); else n_pass++;
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (fill !== 3'd4 || q !== 8'hA1) $display("FAIL bp_pass_after fill=%0d q=%h exp 4/A1", fill, q); else n_pass++;
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++; if (q !== 8'hA1 + 8'(j) || out_valid !== 1'b1) $display("FAIL bp_drain j=%0d q=%h ov=%b exp %h/1", j, q, out_valid, 8'hA1 + 8'(j)); else n_pass++;
      $display("backpressure: delivered %h", q);
      tick();
    end
  endtask

  task automatic test_bubble();
    logic       iv_seq [7];
    logic [7:0] d_seq  [7];
    iv_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    d_seq  = '{8'h5A, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) begin
      drive(iv_seq[i], d_seq[i], 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (fill !== 3'd2) $display("FAIL bub_fill got=%0d exp=2", fill); else n_pass++;
    n_checks++; if (q !== 8'h5A || out_valid !== 1'b1) $display("FAIL bub_head q=%h ov=%b exp 5A/1", q, out_valid); else n_pass++;
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++; if (q !== 8'h5A || out_valid !== 1'b1) $display("FAIL bub_out0 q=%h ov=%b exp 5A/1", q, out_valid); else n_pass++;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++; if (q !== 8'hC3 || out_valid !== 1'b1) $display("FAIL bub_out1 q=%h ov=%b exp C3/1", q, out_valid); else n_pass++;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || empty !== 1'b1) $display("FAIL bub_done ov=%b empty=%b exp 0/1", out_valid, empty); else n_pass++;
    $display("bubble: 5A and C3 delivered back to back");
  endtask

  task automatic test_enable_stall();
    logic [7:0] exp_q[$];
    logic [7:0] hold_q;
    logic [2:0] hold_fill;
    logic [7:0] want;
    int         nxt;
    int         ndel;
    logic       en;
    nxt  = 0;
    ndel = 0;
    hold_q = 8'h00;
    hold_fill = 3'd0;
    for (int c = 0; c < 24; c++) begin
      en = !(c >= 4 && c < 7);
      drive(nxt < 8, 8'h30 + 8'(nxt), 1'b1, en);
      if (c == 4) begin
        hold_q    = q;
        hold_fill = fill;
      end
      if (!en) begin
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL stall_hs c=%0d in_ready=%b ov=%b exp 0/0", c, in_ready, out_valid); else n_pass++;
      end
      if (c >= 5 && c <= 7) begin
        n_checks++; if (q !== hold_q || fill !== hold_fill) $display("FAIL stall_hold c=%0d q=%h fill=%0d exp %h/%0d", c, q, fill, hold_q, hold_fill); else n_pass++;
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_checks++; if (q !== want) $display("FAIL stall_order c=%0d got=%h exp=%h", c, q, want); else n_pass++;
        $display("stall: delivered %h", q);
        ndel++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(d);
        nxt++;
      end
      tick();
    end
    n_checks++; if (ndel !== 8) $display("FAIL stall_count got=%0d exp=8", ndel); else n_pass++;
  endtask

`ifdef DFFE_PIPE_SCLR_EN
  task automatic test_sclr();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h90 + 8'(i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 8'h77, 1'b1, 1'b1);
    sclr = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL sclr_hs in_ready=%b ov=%b exp 0/0", in_ready, out_valid); else n_pass++;
    @(posedge clk);
    model_reset();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    sclr = 1'b0;
    #1;
    n_checks++; if (fill !== 3'd0 || q !== 8'h00 || empty !== 1'b1) $display("FAIL sclr_clear fill=%0d q=%h empty=%b exp 0/00/1", fill, q, empty); else n_pass++;
    $display("sclr: pipe cleared");
  endtask
`endif

  task automatic test_random();
    logic iv, ordy, en;
    logic [7:0] dd;
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      en   = ($urandom_range(0, 9) != 0);
      dd   = 8'($urandom);
      drive(iv, dd, ordy, en);
      n_checks++; if (out_valid !== m_out_valid(en)) $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, m_out_valid(en)); else n_pass++;
      n_checks++; if (q !== m_q) $display("FAIL rnd_q c=%0d got=%h exp=%h", c, q, m_q); else n_pass++;
      n_checks++; if (in_ready !== m_in_ready(ordy, en)) $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_in_ready(ordy, en)); else n_pass++;
      n_checks++; if (fill !== 3'(m_pos.size())) $display("FAIL rnd_fill c=%0d got=%0d exp=%0d", c, fill, m_pos.size()); else n_pass++;
      n_checks++; if (full !== (m_pos.size() == DEPTH) || empty !== (m_pos.size() == 0)) $display("FAIL rnd_flags c=%0d full=%b empty=%b exp fill=%0d", c, full, empty, m_pos.size()); else n_pass++;
      tick();
    end
  endtask

  initial begin
    clrn      = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = 8'h00;
`ifdef DFFE_PIPE_SCLR_EN
    sclr      = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_enable_stall();
`ifdef DFFE_PIPE_SCLR_EN
    test_sclr();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
